mc_dfi_rddata_aligner: RTL and testbench
========================================

// Module: mc_dfi_rddata_aligner
// PURPOSE
//  Read-return stage between the 4-phase DFI read-data pins and the core read path.
//  Gathers per-phase 64b beats (valid may start on any phase), assembles 256b words, buffers them
//  in a FIFO toward the core. Credit-gates read issue so the FIFO can never overflow.
//  Flags protocol faults: misaligned valid, unexpected data, timeout.
// PARAMETERS
//  FIFO_DEPTH   8     256b words buffered; power of 2, >=2
//  TIMEOUT_CYC  255   max cycles with reads outstanding and no rddata_valid before err_timeout
// PORTS
//  sys_clk            in   1     sole clock
//  sys_rst_n          in   1     async assert, active-low reset
//  dfi_rddata         in   256   {p3,p2,p1,p0} 64b per-phase read data, p0 = bits[63:0]
//  dfi_rddata_valid   in   4     per-phase valid, bit N = phase N
//  rd_issue           in   1     core issued one read command (expects exactly one 256b word)
//  rd_issue_ready     out  1     core may assert rd_issue this cycle
//  rd_valid           out  1     FIFO head valid
//  rd_ready           in   1     core accepts head
//  rd_data            out  256   FIFO head word
//  outstanding        out  $clog2(FIFO_DEPTH)+1  reads issued but not yet assembled
//  err_align          out  1     sticky: non-contiguous valid pattern seen
//  err_unexp          out  1     sticky: valid beats with outstanding==0
//  err_timeout        out  1     sticky: TIMEOUT_CYC reached
//  err_clr            in   1     clears all sticky errors (priority below same-cycle set)
// BEHAVIOUR
//  Reset: rd_issue_ready=1, rd_valid=0, rd_data=0, outstanding=0, all err_*=0; FIFO, residual, timer cleared.
//   Reset mid-burst drops residual and FIFO contents; no word is emitted afterwards.
//  Legal valid patterns are a contiguous run: 0000, 1111, prefixes (0001,0011,0111), suffixes (1000,1100,1110),
//   and interior runs (0010,0110,0100). Any other (e.g. 0101, 1011) -> err_align=1, cycle's data dropped,
//   residual kept.
//  Assembly: residual reg holds rcnt (0..3) beats, packed from bit 0 upward. New valid beats (vcnt 0..4),
//   compacted lowest phase first, are appended above the residual. If rcnt+vcnt>=4, emit the low 4 beats
//   as one word and new rcnt=rcnt+vcnt-4. Else rcnt+=vcnt. Width of sum: 3 bits (max 7).
//  Emit: FIFO push same cycle; rd_valid visible next cycle (latency 1 from completing beat). FIFO is show-ahead.
//  outstanding: +1 on rd_issue&&rd_issue_ready, -1 on emit; both same cycle -> unchanged.
//   rd_issue while !rd_issue_ready is ignored.
//  rd_issue_ready = (outstanding + fifo_count) < FIFO_DEPTH, combinational from registered state.
//  Emit with outstanding==0 -> err_unexp=1, word still pushed if FIFO not full, outstanding stays 0 (no underflow).
//  FIFO full and emit with no same-cycle pop -> word dropped; err_unexp is set, since credits make
//   this unreachable otherwise. Full plus pop plus push in the same cycle is legal; count unchanged.
//  Timer: cleared when outstanding==0 or any valid bit set; else increments, saturating.
//   On reaching TIMEOUT_CYC: err_timeout=1, residual flushed (rcnt=0), outstanding forced to 0.
//  err_clr same cycle as a new error set -> error stays 1.
//  Word/phase mapping: beat k of an assembled word lands in rd_data[64k+63:64k].
// STRUCTURE
//  Package mc_dfi_pkg: NPHASES=4, PHASE_DW=64, WORD_DW=256, typedef logic [PHASE_DW-1:0] phase_beat_t,
//   function popcount4 and contiguous-run check.
//  Sub-module mc_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, show-ahead) holds the output buffer.
//  Aligner FSM is implicit in rcnt (0..3); timer and credit logic live in the top.
// TESTING
//  1 rd_issue x1; cycle+5 valid=1111 data p0..p3=A0..A3 -> next cycle rd_valid=1, rd_data={A3,A2,A1,A0}, outstanding 1->0.
//  2 rd_issue x2; valid=1100(B0,B1) then 1111(B2,B3,C0,C1) then 0011(C2,C3) -> words {B3..B0} then {C3..C0}, rcnt ends 0.
//  3 FIFO_DEPTH=8, rd_ready=0, issue 8 reads -> rd_issue_ready=0 after 8th; 9th rd_issue ignored; deliver 8 words, pop 1 -> ready=1.
//  4 valid=0101 with 1 outstanding -> err_align=1, no word, outstanding=1; then err_clr -> err_align=0.
//  5 rd_issue, no data for 255 cycles -> err_timeout=1, outstanding=0; later valid=1111 -> err_unexp=1, word pushed.
//  6 assert sys_rst_n low while rcnt=2 and FIFO holds 3 -> all outputs at reset values, rd_valid stays 0 after release.

Source files
------------

// File: rtl/mc_dfi_rddata_aligner_pkg.sv
// Shared widths and small helpers for the DFI read-data return path.
package mc_dfi_pkg;

   localparam int NPHASES  = 4;
   localparam int PHASE_DW = 64;
   localparam int WORD_DW  = NPHASES * PHASE_DW;

   typedef logic [PHASE_DW-1:0] phase_beat_t;

   // Number of valid phases in one DFI cycle (0..4).
   function automatic logic [2:0] popcount4(input logic [NPHASES-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NPHASES; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   // Index of the lowest valid phase; 0 when nothing is valid.
   function automatic logic [1:0] lowest4(input logic [NPHASES-1:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int i = NPHASES - 1; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // True when the set bits form one unbroken run (or no bits are set).
   // After shifting the run down to bit 0 it looks like 0..01..1, and adding
   // one to such a value never shares a bit with it.
   function automatic logic is_contig4(input logic [NPHASES-1:0] v);
      logic [NPHASES-1:0] s;
      s = v >> lowest4(v);
      return (s & (s + 4'd1)) == 4'd0;
   endfunction

endpackage

// File: rtl/mc_dfi_rddata_aligner_if.sv
// DFI read-data pins plus the core-side read issue / read return handshake.
interface mc_dfi_rddata_aligner_if;
   import mc_dfi_pkg::*;

   logic [WORD_DW-1:0] dfi_rddata;
   logic [NPHASES-1:0] dfi_rddata_valid;
   logic               rd_issue;
   logic               rd_issue_ready;
   logic               rd_valid;
   logic               rd_ready;
   logic [WORD_DW-1:0] rd_data;

   modport slave (
      input  dfi_rddata, dfi_rddata_valid, rd_issue, rd_ready,
      output rd_issue_ready, rd_valid, rd_data
   );

   modport master (
      output dfi_rddata, dfi_rddata_valid, rd_issue, rd_ready,
      input  rd_issue_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/mc_dfi_rddata_aligner_fifo.sv
// Show-ahead synchronous FIFO. Head word is presented whenever not empty and
// reads as zero when empty. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module mc_sync_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rptr_q];

   // Pointer, occupancy and storage updates for one push and/or pop.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset discards all buffered words.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mc_dfi_rddata_aligner.sv
// Read-return aligner: packs per-phase DFI read beats into 256b words, buffers
// them toward the core, credit-gates read issue and flags protocol faults.
//
// The aligner state is the residual beat count rcnt:
//   rcnt | meaning
//   0    | no partial word held
//   1    | beat 0 of the next word held
//   2    | beats 0..1 of the next word held
//   3    | beats 0..2 of the next word held
module mc_dfi_rddata_aligner
   import mc_dfi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 255,
   localparam int OW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   mc_dfi_rddata_aligner_if.slave  bus,
   output logic [OW-1:0]           outstanding,
   output logic                    err_align,
   output logic                    err_unexp,
   output logic                    err_timeout,
   input  logic                    err_clr
);

   localparam int TW     = $clog2(TIMEOUT_CYC + 1);
   localparam int RES_DW = (NPHASES - 1) * PHASE_DW;
   localparam int MRG_DW = (2 * NPHASES - 1) * PHASE_DW;

   logic [1:0]         rcnt_q, rcnt_d;
   logic [RES_DW-1:0]  res_q, res_d;
   logic [OW-1:0]      outstanding_q, outstanding_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               err_align_q, err_align_d;
   logic               err_unexp_q, err_unexp_d;
   logic               err_timeout_q, err_timeout_d;

   logic [NPHASES-1:0] vld;
   logic               any_vld, legal, accept, emit;
   logic [2:0]         vcnt, sum;
   logic [WORD_DW-1:0] masked, compacted, word;
   logic [MRG_DW-1:0]  merged;

   logic               timeout, count_en, out_zero;
   logic               issue_ready, issue_acc, out_dec;
   logic [OW:0]        credit_sum;

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
   logic [OW-1:0]      fifo_count;
   logic [WORD_DW-1:0] fifo_rdata;

   // Compact this cycle's valid beats and append them above the residual.
   always_comb begin
      vld     = bus.dfi_rddata_valid;
      any_vld = |vld;
      legal   = is_contig4(vld);
      vcnt    = popcount4(vld);
      for (int p = 0; p < NPHASES; p++) begin
         masked[p*PHASE_DW +: PHASE_DW] = vld[p] ? bus.dfi_rddata[p*PHASE_DW +: PHASE_DW]
                                                 : phase_beat_t'(0);
      end
      compacted = masked >> (PHASE_DW * int'(lowest4(vld)));
      merged    = MRG_DW'(res_q) | (MRG_DW'(compacted) << (PHASE_DW * int'(rcnt_q)));
      sum       = {1'b0, rcnt_q} + vcnt;
      accept    = any_vld && legal;
      emit      = accept && sum[2];
      word      = merged[WORD_DW-1:0];
   end

   // Next residual: leftover beats after an emit, flushed on timeout.
   always_comb begin
      rcnt_d = rcnt_q;
      res_d  = res_q;
      if (timeout) begin
         rcnt_d = '0;
         res_d  = '0;
      end else if (accept) begin
         rcnt_d = sum[1:0];
         res_d  = emit ? merged[MRG_DW-1:WORD_DW] : merged[RES_DW-1:0];
      end
   end

   // Credit accounting and the no-data watchdog (down-counter to terminal count).
   always_comb begin
      out_zero      = (outstanding_q == '0);
      credit_sum    = {1'b0, outstanding_q} + {1'b0, fifo_count};
      issue_ready   = credit_sum < (OW+1)'(FIFO_DEPTH);
      issue_acc     = bus.rd_issue && issue_ready;
      out_dec       = emit && !out_zero;
      count_en      = !out_zero && !any_vld;
      timeout       = count_en && (timer_q == TW'(1));
      timer_d       = (!count_en || timeout) ? TW'(TIMEOUT_CYC) : timer_q - TW'(1);
      outstanding_d = outstanding_q;
      if (timeout) begin
         outstanding_d = issue_acc ? OW'(1) : '0;
      end else begin
         case ({issue_acc, out_dec})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
         endcase
      end
   end

   // FIFO handshake and sticky error flags; a same-cycle set beats err_clr.
   always_comb begin
      fifo_pop      = !fifo_empty && bus.rd_ready;
      fifo_push     = emit && (!fifo_full || fifo_pop);
      fifo_drop     = emit && fifo_full && !fifo_pop;
      err_align_d   = (err_align_q && !err_clr) || (any_vld && !legal);
      err_unexp_d   = (err_unexp_q && !err_clr) || (any_vld && out_zero) || fifo_drop;
      err_timeout_d = (err_timeout_q && !err_clr) || timeout;
   end

   // State registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rcnt_q        <= '0;
         res_q         <= '0;
         outstanding_q <= '0;
         timer_q       <= TW'(TIMEOUT_CYC);
         err_align_q   <= 1'b0;
         err_unexp_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         rcnt_q        <= rcnt_d;
         res_q         <= res_d;
         outstanding_q <= outstanding_d;
         timer_q       <= timer_d;
         err_align_q   <= err_align_d;
         err_unexp_q   <= err_unexp_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   mc_sync_fifo #(
      .WIDTH (WORD_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (fifo_push),
      .wdata     (word),
      .pop       (fifo_pop),
      .rdata     (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.rd_issue_ready = issue_ready;
   assign bus.rd_valid       = !fifo_empty;
   assign bus.rd_data        = fifo_rdata;
   assign outstanding        = outstanding_q;
   assign err_align          = err_align_q;
   assign err_unexp          = err_unexp_q;
   assign err_timeout        = err_timeout_q;

endmodule

// File: tb/tb_mc_dfi_rddata_aligner.sv
// Bench for the DFI read-data aligner: directed scenarios with literal
// expectations plus randomized traffic, all checked against a queue-based model.
module tb_mc_dfi_rddata_aligner;
   localparam int DEPTH = 8;
   localparam int TMO   = 255;

   logic       clk;
   logic       rst_n;
   logic       err_clr;
   logic [3:0] outstanding;
   logic       err_align, err_unexp, err_timeout;

   mc_dfi_rddata_aligner_if bus();

   mc_dfi_rddata_aligner #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .bus         (bus),
      .outstanding (outstanding),
      .err_align   (err_align),
      .err_unexp   (err_unexp),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncheck = 0;
   int nbad   = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      ncheck++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0]  m_res[$];
   logic [255:0] m_fifo[$];
   int           m_out   = 0;
   int           m_timer = 0;
   bit           m_ea = 0, m_eu = 0, m_et = 0;
   bit           mv_any, mv_pop, mv_acc, mv_emit, mv_tmo, s_al, s_un;
   logic [3:0]   mv_v;
   logic [255:0] mv_w;

   function automatic bit legal_pat(input logic [3:0] v);
      return v inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h8, 4'hC, 4'hE, 4'h2, 4'h6, 4'h4};
   endfunction

   always @(negedge rst_n) begin
      m_res.delete();
      m_fifo.delete();
      m_out = 0; m_timer = 0;
      m_ea = 0; m_eu = 0; m_et = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         mv_v    = bus.dfi_rddata_valid;
         mv_any  = (mv_v != 4'h0);
         mv_pop  = (m_fifo.size() > 0) && bus.rd_ready;
         mv_acc  = bus.rd_issue && (m_out + m_fifo.size() < DEPTH);
         s_al = 0; s_un = 0; mv_emit = 0; mv_tmo = 0;
         if (mv_any && m_out == 0) s_un = 1;
         if (mv_any && !legal_pat(mv_v)) s_al = 1;
         else if (mv_any) begin
            for (int i = 0; i < 4; i++)
               if (mv_v[i]) m_res.push_back(bus.dfi_rddata[64*i +: 64]);
            if (m_res.size() >= 4) begin
               mv_w = {m_res[3], m_res[2], m_res[1], m_res[0]};
               repeat (4) void'(m_res.pop_front());
               mv_emit = 1;
            end
         end
         if (m_out == 0 || mv_any) m_timer = 0;
         else begin
            m_timer++;
            if (m_timer == TMO) mv_tmo = 1;
         end
         if (mv_pop) void'(m_fifo.pop_front());
         if (mv_emit) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(mv_w);
            else s_un = 1;
         end
         if (mv_tmo) begin
            m_res.delete();
            m_timer = 0;
            m_out = mv_acc ? 1 : 0;
         end else begin
            if (mv_emit && m_out > 0) m_out--;
            if (mv_acc) m_out++;
         end
         m_ea = (m_ea && !err_clr) || s_al;
         m_eu = (m_eu && !err_clr) || s_un;
         m_et = (m_et && !err_clr) || mv_tmo;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_ready", bus.rd_issue_ready, (m_out + m_fifo.size() < DEPTH));
      chk("m_rd_valid", bus.rd_valid, (m_fifo.size() > 0));
      chk("m_rd_data", bus.rd_data, (m_fifo.size() > 0) ? m_fifo[0] : 256'h0);
      chk("m_outstanding", outstanding, m_out);
      chk("m_err_align", err_align, m_ea);
      chk("m_err_unexp", err_unexp, m_eu);
      chk("m_err_timeout", err_timeout, m_et);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [63:0] bt(input logic [31:0] tag, input int j);
      return {tag, 32'(j)};
   endfunction

   function automatic logic [255:0] wd(input logic [31:0] tag);
      return {bt(tag, 3), bt(tag, 2), bt(tag, 1), bt(tag, 0)};
   endfunction

   task automatic idle();
      bus.rd_issue = 0;
      bus.dfi_rddata_valid = 4'h0;
      bus.dfi_rddata = rand256();
      err_clr = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   logic [255:0] d;
   logic [3:0]   rv;
   logic [3:0]   legal_list [10];

   initial begin
      legal_list = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h8, 4'hC, 4'hE, 4'h2, 4'h6, 4'h4};
      rst_n = 1'b1;
      bus.rd_ready = 0;
      idle();
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_ready", bus.rd_issue_ready, 1);
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_data", bus.rd_data, 0);
      chk("rst_out", outstanding, 0);
      #2 rst_n = 1'b1;
      tick();

      // 1: single read, full-width beat set
      bus.rd_issue = 1; tick(); bus.rd_issue = 0;
      chk("t1_out1", outstanding, 1);
      repeat (4) tick();
      bus.dfi_rddata_valid = 4'hF; bus.dfi_rddata = wd(32'hA0A0_0000);
      tick(); idle();
      chk("t1_valid", bus.rd_valid, 1);
      chk("t1_data", bus.rd_data, wd(32'hA0A0_0000));
      chk("t1_out0", outstanding, 0);
      bus.rd_ready = 1; tick(); bus.rd_ready = 0;
      chk("t1_empty", bus.rd_valid, 0);

      // 2: split beats across cycles
      bus.rd_issue = 1; tick(); tick(); bus.rd_issue = 0;
      chk("t2_out2", outstanding, 2);
      bus.dfi_rddata_valid = 4'hC;
      d = rand256(); d[191:128] = bt(32'hB, 0); d[255:192] = bt(32'hB, 1);
      bus.dfi_rddata = d; tick();
      chk("t2_nowd", bus.rd_valid, 0);
      bus.dfi_rddata_valid = 4'hF;
      bus.dfi_rddata = {bt(32'hC, 1), bt(32'hC, 0), bt(32'hB, 3), bt(32'hB, 2)};
      tick();
      chk("t2_wB", bus.rd_data, wd(32'hB));
      chk("t2_out1", outstanding, 1);
      bus.dfi_rddata_valid = 4'h3;
      d = rand256(); d[63:0] = bt(32'hC, 2); d[127:64] = bt(32'hC, 3);
      bus.dfi_rddata = d; tick(); idle();
      chk("t2_out0", outstanding, 0);
      bus.rd_ready = 1; tick();
      chk("t2_wC", bus.rd_data, wd(32'hC));
      tick(); bus.rd_ready = 0;
      chk("t2_empty", bus.rd_valid, 0);

      // 3: credits exhausted, ninth issue ignored
      bus.rd_issue = 1;
      repeat (8) tick();
      chk("t3_notready", bus.rd_issue_ready, 0);
      tick(); bus.rd_issue = 0;
      chk("t3_out8", outstanding, 8);
      for (int k = 0; k < 8; k++) begin
         bus.dfi_rddata_valid = 4'hF; bus.dfi_rddata = wd(32'h3000 + 32'(k)); tick();
      end
      idle();
      chk("t3_full_notready", bus.rd_issue_ready, 0);
      chk("t3_head", bus.rd_data, wd(32'h3000));
      bus.rd_ready = 1; tick(); bus.rd_ready = 0;
      chk("t3_ready_again", bus.rd_issue_ready, 1);
      chk("t3_head2", bus.rd_data, wd(32'h3001));
      bus.rd_ready = 1; repeat (7) tick(); bus.rd_ready = 0;
      chk("t3_drained", bus.rd_valid, 0);

      // 4: misaligned pattern, then clear; clear loses to same-cycle set
      bus.rd_issue = 1; tick(); bus.rd_issue = 0;
      bus.dfi_rddata_valid = 4'h5; tick(); idle();
      chk("t4_align", err_align, 1);
      chk("t4_noword", bus.rd_valid, 0);
      chk("t4_out1", outstanding, 1);
      err_clr = 1; tick(); err_clr = 0;
      chk("t4_clr", err_align, 0);
      bus.dfi_rddata_valid = 4'hB; err_clr = 1; tick(); idle();
      chk("t4_setwins", err_align, 1);
      err_clr = 1; tick(); err_clr = 0;
      bus.dfi_rddata_valid = 4'hF; tick(); idle();
      chk("t4_word", bus.rd_valid, 1);
      bus.rd_ready = 1; tick(); bus.rd_ready = 0;

      // 5: timeout boundary, then unexpected data
      bus.rd_issue = 1; tick(); bus.rd_issue = 0;
      repeat (254) tick();
      chk("t5_before", err_timeout, 0);
      chk("t5_out_before", outstanding, 1);
      tick();
      chk("t5_tmo", err_timeout, 1);
      chk("t5_out0", outstanding, 0);
      bus.dfi_rddata_valid = 4'hF; bus.dfi_rddata = wd(32'h5555); tick(); idle();
      chk("t5_unexp", err_unexp, 1);
      chk("t5_pushed", bus.rd_data, wd(32'h5555));
      bus.rd_ready = 1; err_clr = 1; tick(); bus.rd_ready = 0; err_clr = 0;
      chk("t5_clr", err_timeout, 0);

      // 6: reset mid-burst
      bus.rd_issue = 1; repeat (4) tick(); bus.rd_issue = 0;
      for (int k = 0; k < 3; k++) begin
         bus.dfi_rddata_valid = 4'hF; bus.dfi_rddata = rand256(); tick();
      end
      bus.dfi_rddata_valid = 4'hC; tick(); idle();
      chk("t6_pre_valid", bus.rd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", bus.rd_valid, 0);
      chk("t6_rst_out", outstanding, 0);
      chk("t6_rst_ready", bus.rd_issue_ready, 1);
      chk("t6_rst_data", bus.rd_data, 0);
      tick(); #2 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t6_stay_empty", bus.rd_valid, 0);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.rd_issue = ($urandom_range(0, 2) == 0);
         bus.rd_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         err_clr = ($urandom_range(0, 31) == 0);
         bus.dfi_rddata = rand256();
         case ($urandom_range(0, 7))
            4, 5, 6: bus.dfi_rddata_valid = legal_list[$urandom_range(0, 9)];
            7: begin rv = 4'($urandom); bus.dfi_rddata_valid = rv; end
            default: bus.dfi_rddata_valid = 4'h0;
         endcase
         tick();
      end
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", ncheck, nbad);
      $finish;
   end

endmodule
